// File: rtl/rv32_exec_alu_pkg.sv
// Shared RV32I encodings for the execute-stage ALU: opcodes, funct3 codes
// and the immediate-format classification used by the immediate decoder.
package rv32_exec_alu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: fmt = IMM_I;
      OP_STORE:                            fmt = IMM_S;
      OP_BRANCH:                           fmt = IMM_B;
      OP_LUI, OP_AUIPC:                    fmt = IMM_U;
      OP_JAL:                              fmt = IMM_J;
      default:                             fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/rv32_exec_alu_imm_decode.sv
// Combinational RV32I immediate decoder: raw instruction word in,
// sign-extended (or upper) immediate out; unknown formats yield zero.
module rv32_imm_decode
  import rv32_exec_alu_pkg::*;
(
  input  logic [31:0] inst,
  output logic [31:0] imm
);

  imm_fmt_e fmt;

  assign fmt = imm_format(inst[6:0]);

  always_comb begin
    // NOTE: every path assigns imm (default arm included), so no latch is inferred.
    case (fmt)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/rv32_exec_alu.sv
// RV32I execute-stage ALU, branch comparator and immediate decoder, with
// zero-latency outputs plus registered copies for the EX/MEM register.
module rv32_exec_alu
  import rv32_exec_alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  output logic [XLEN-1:0] result,
  output logic            take_b,
  output logic [31:0]     imm,
  output logic [XLEN-1:0] result_q,
  output logic            take_b_q,
  output logic [31:0]     imm_q
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic            alt;
  logic [4:0]      shamt;
  logic [XLEN-1:0] result_d;
  logic            take_b_d;
  logic [31:0]     imm_d;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign alt    = inst[30];
  assign shamt  = in_b[4:0];

  rv32_imm_decode u_imm_decode (
    .inst (inst),
    .imm  (imm_d)
  );

  // Non-ALU opcodes reuse the adder for link addresses, AUIPC and address generation.
  always_comb begin
    result_d = in_a + in_b;
    if (opcode == OP_R || opcode == OP_IMM) begin
      case (funct3)
        F3_ADD:  result_d = (opcode == OP_R && alt) ? in_a - in_b : in_a + in_b;
        F3_SLL:  result_d = in_a << shamt;
        F3_SLT:  result_d = {{(XLEN-1){1'b0}}, $signed(in_a) < $signed(in_b)};
        F3_SLTU: result_d = {{(XLEN-1){1'b0}}, in_a < in_b};
        F3_XOR:  result_d = in_a ^ in_b;
        F3_SR:   result_d = alt ? $unsigned($signed(in_a) >>> shamt) : in_a >> shamt;
        F3_OR:   result_d = in_a | in_b;
        F3_AND:  result_d = in_a & in_b;
        default: result_d = in_a + in_b;
      endcase
    end
  end

  always_comb begin
    take_b_d = 1'b0;
    if (opcode == OP_BRANCH) begin
      case (funct3)
        F3_BEQ:  take_b_d = (in_a == in_b);
        F3_BNE:  take_b_d = (in_a != in_b);
        F3_BLT:  take_b_d = ($signed(in_a) < $signed(in_b));
        F3_BGE:  take_b_d = ($signed(in_a) >= $signed(in_b));
        F3_BLTU: take_b_d = (in_a < in_b);
        F3_BGEU: take_b_d = (in_a >= in_b);
        default: take_b_d = 1'b0;
      endcase
    end
  end

  assign result = result_d;
  assign take_b = take_b_d;
  assign imm    = imm_d;

  // NOTE: synchronous reset; all state here is plain pipeline flops, so every one is cleared.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep flop updates order-independent.
    if (!resetn) begin
      result_q <= '0;
      take_b_q <= 1'b0;
      imm_q    <= '0;
    end else begin
      result_q <= result_d;
      take_b_q <= take_b_d;
      imm_q    <= imm_d;
    end
  end

endmodule

// File: tb/tb_rv32_exec_alu.sv
// Directed self-checking bench for rv32_exec_alu: ALU ops, branch compares,
// immediate formats and the registered output stage.
module tb_rv32_exec_alu;

  logic        clk;
  logic        resetn;
  logic [31:0] inst;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] result;
  logic        take_b;
  logic [31:0] imm;
  logic [31:0] result_q;
  logic        take_b_q;
  logic [31:0] imm_q;

  int n_cmp;
  int n_err;

  rv32_exec_alu dut (
    .clk      (clk),
    .resetn   (resetn),
    .inst     (inst),
    .in_a     (in_a),
    .in_b     (in_b),
    .result   (result),
    .take_b   (take_b),
    .imm      (imm),
    .result_q (result_q),
    .take_b_q (take_b_q),
    .imm_q    (imm_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    inst = i;
    in_a = a;
    in_b = b;
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    inst   = 32'h0000_0033;
    in_a   = 32'h1234_5678;
    in_b   = 32'h1111_1111;
    @(posedge clk);
    #1;
    n_cmp++;
    if (result_q !== 32'h0 || take_b_q !== 1'b0 || imm_q !== 32'h0) begin
      n_err++;
      $display("FAIL reset_q: result_q=%h take_b_q=%b imm_q=%h expected all zero", result_q, take_b_q, imm_q);
    end
  endtask

  task automatic test_r_type;
    apply(32'h4000_0033, 32'd5, 32'd7);
    n_cmp++;
    if (result !== 32'hFFFF_FFFE) begin
      n_err++;
      $display("FAIL r_sub: result=%h expected=%h", result, 32'hFFFF_FFFE);
    end
    n_cmp++;
    if (imm !== 32'h0) begin
      n_err++;
      $display("FAIL r_imm: imm=%h expected=%h", imm, 32'h0);
    end
    apply(32'h0000_0033, 32'd5, 32'd7);
    n_cmp++;
    if (result !== 32'd12) begin
      n_err++;
      $display("FAIL r_add: result=%h expected=%h", result, 32'd12);
    end
    apply(32'h0000_2033, 32'hFFFF_FFFF, 32'd1);
    n_cmp++;
    if (result !== 32'd1) begin
      n_err++;
      $display("FAIL r_slt: result=%h expected=%h", result, 32'd1);
    end
    apply(32'h0000_1033, 32'd1, 32'h0000_0021);
    n_cmp++;
    if (result !== 32'd2) begin
      n_err++;
      $display("FAIL r_sll_shamt5: result=%h expected=%h", result, 32'd2);
    end
    apply(32'h0000_4033, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_cmp++;
    if (result !== 32'h0FF0_0FF0) begin
      n_err++;
      $display("FAIL r_xor: result=%h expected=%h", result, 32'h0FF0_0FF0);
    end
    apply(32'h0000_6033, 32'hF0F0_F0F0, 32'h0F00_0F00);
    n_cmp++;
    if (result !== 32'hFFF0_FFF0) begin
      n_err++;
      $display("FAIL r_or: result=%h expected=%h", result, 32'hFFF0_FFF0);
    end
    apply(32'h0000_7033, 32'hF0F0_F0F0, 32'hFF00_FF00);
    n_cmp++;
    if (result !== 32'hF000_F000) begin
      n_err++;
      $display("FAIL r_and: result=%h expected=%h", result, 32'hF000_F000);
    end
  endtask

  task automatic test_op_imm;
    apply(32'h4030_D093, 32'h8000_0000, 32'h0000_0403);
    n_cmp++;
    if (imm !== 32'h0000_0403) begin
      n_err++;
      $display("FAIL srai_imm: imm=%h expected=%h", imm, 32'h0000_0403);
    end
    n_cmp++;
    if (result !== 32'hF000_0000) begin
      n_err++;
      $display("FAIL srai: result=%h expected=%h", result, 32'hF000_0000);
    end
    apply(32'h0030_D093, 32'h8000_0000, 32'h0000_0003);
    n_cmp++;
    if (result !== 32'h1000_0000) begin
      n_err++;
      $display("FAIL srli: result=%h expected=%h", result, 32'h1000_0000);
    end
    apply(32'hFFF0_3013, 32'h0, 32'hFFFF_FFFF);
    n_cmp++;
    if (result !== 32'd1 || imm !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL sltiu: result=%h imm=%h expected result=1 imm=ffffffff", result, imm);
    end
    apply(32'h4000_0013, 32'd5, 32'h0000_0400);
    n_cmp++;
    if (result !== 32'h0000_0405) begin
      n_err++;
      $display("FAIL addi_bit30: result=%h expected=%h", result, 32'h0000_0405);
    end
  endtask

  task automatic test_branch;
    apply(32'h0000_4063, 32'hFFFF_FFFF, 32'd1);
    n_cmp++;
    if (take_b !== 1'b1) begin
      n_err++;
      $display("FAIL blt: take_b=%b expected=1", take_b);
    end
    apply(32'h0000_6063, 32'hFFFF_FFFF, 32'd1);
    n_cmp++;
    if (take_b !== 1'b0) begin
      n_err++;
      $display("FAIL bltu: take_b=%b expected=0", take_b);
    end
    apply(32'h0000_5063, 32'hFFFF_FFFF, 32'd1);
    n_cmp++;
    if (take_b !== 1'b0) begin
      n_err++;
      $display("FAIL bge: take_b=%b expected=0", take_b);
    end
    apply(32'h0000_7063, 32'hFFFF_FFFF, 32'd1);
    n_cmp++;
    if (take_b !== 1'b1) begin
      n_err++;
      $display("FAIL bgeu: take_b=%b expected=1", take_b);
    end
    apply(32'h0000_1063, 32'd9, 32'd9);
    n_cmp++;
    if (take_b !== 1'b0) begin
      n_err++;
      $display("FAIL bne_equal: take_b=%b expected=0", take_b);
    end
    apply(32'h0000_2063, 32'd1, 32'd2);
    n_cmp++;
    if (take_b !== 1'b0) begin
      n_err++;
      $display("FAIL br_f3_010: take_b=%b expected=0", take_b);
    end
    apply(32'hFE00_0CE3, 32'h55AA_55AA, 32'h55AA_55AA);
    n_cmp++;
    if (take_b !== 1'b1 || imm !== 32'hFFFF_FFF8) begin
      n_err++;
      $display("FAIL beq_m8: take_b=%b imm=%h expected take_b=1 imm=fffffff8", take_b, imm);
    end
    apply(32'h0000_0033, 32'd3, 32'd3);
    n_cmp++;
    if (take_b !== 1'b0) begin
      n_err++;
      $display("FAIL add_no_branch: take_b=%b expected=0", take_b);
    end
  endtask

  task automatic test_imm_decode;
    apply(32'hFFDF_F0EF, 32'h0000_0100, 32'd4);
    n_cmp++;
    if (imm !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL jal_imm: imm=%h expected=%h", imm, 32'hFFFF_FFFC);
    end
    n_cmp++;
    if (result !== 32'h0000_0104) begin
      n_err++;
      $display("FAIL jal_link: result=%h expected=%h", result, 32'h0000_0104);
    end
    apply(32'h1234_50B7, 32'h0, 32'h0);
    n_cmp++;
    if (imm !== 32'h1234_5000) begin
      n_err++;
      $display("FAIL lui_imm: imm=%h expected=%h", imm, 32'h1234_5000);
    end
    apply(32'hFE11_2E23, 32'h0000_1000, 32'hFFFF_FFFC);
    n_cmp++;
    if (imm !== 32'hFFFF_FFFC || result !== 32'h0000_0FFC) begin
      n_err++;
      $display("FAIL sw: imm=%h result=%h expected imm=fffffffc result=00000ffc", imm, result);
    end
    apply(32'h0000_1017, 32'h8000_0000, 32'h0000_1000);
    n_cmp++;
    if (imm !== 32'h0000_1000 || result !== 32'h8000_1000) begin
      n_err++;
      $display("FAIL auipc: imm=%h result=%h expected imm=00001000 result=80001000", imm, result);
    end
    apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2);
    n_cmp++;
    if (imm !== 32'h0 || result !== 32'd1 || take_b !== 1'b0) begin
      n_err++;
      $display("FAIL unknown_op: imm=%h result=%h take_b=%b expected 0/1/0", imm, result, take_b);
    end
  endtask

  task automatic test_registers;
    @(negedge clk);
    resetn = 1'b1;
    inst   = 32'h0000_0033;
    in_a   = 32'd3;
    in_b   = 32'd4;
    @(posedge clk);
    #1;
    n_cmp++;
    if (result_q !== 32'd7 || take_b_q !== 1'b0 || imm_q !== 32'h0) begin
      n_err++;
      $display("FAIL reg_add: result_q=%h take_b_q=%b imm_q=%h expected 7/0/0", result_q, take_b_q, imm_q);
    end
    @(negedge clk);
    inst = 32'hFE00_0CE3;
    in_a = 32'd6;
    in_b = 32'd6;
    n_cmp++;
    if (result_q !== 32'd7) begin
      n_err++;
      $display("FAIL reg_hold: result_q=%h expected=%h", result_q, 32'd7);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (result_q !== 32'd12 || take_b_q !== 1'b1 || imm_q !== 32'hFFFF_FFF8) begin
      n_err++;
      $display("FAIL reg_beq: result_q=%h take_b_q=%b imm_q=%h expected 0000000c/1/fffffff8", result_q, take_b_q, imm_q);
    end
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (result_q !== 32'h0 || take_b_q !== 1'b0 || imm_q !== 32'h0) begin
      n_err++;
      $display("FAIL reg_midreset: result_q=%h take_b_q=%b imm_q=%h expected all zero", result_q, take_b_q, imm_q);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_r_type();
    test_op_imm();
    test_branch();
    test_imm_decode();
    test_registers();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rv32_exec_alu.md
Name: rv32_exec_alu

Overview:
RV32I execute-stage arithmetic block: an ALU plus an immediate decoder, both driven by the raw 32-bit instruction word.
- Produces the ALU result, the branch-taken flag and the sign-extended immediate combinationally, for same-cycle use by the execute stage.
- Also provides registered copies of these outputs for the next pipeline register.
- Sits between the decode/execute register and the execute/memory register of the 5-stage core.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
inst  in  32  instruction word in execute stage
in_a  in  32  ALU operand A (rs1 or PC, selected outside)
in_b  in  32  ALU operand B (rs2, immediate or 4, selected outside)
result  out  32  combinational ALU result
take_b  out  1  combinational branch-condition result
imm  out  32  combinational decoded immediate of inst
result_q  out  32  result registered at posedge clk
take_b_q  out  1  take_b registered
imm_q  out  32  imm registered

Behaviour:
- Combinational outputs have zero latency and no state.
- Registered outputs: one-cycle latency. On posedge clk with resetn=0, all *_q outputs become 0; otherwise each *_q captures its combinational counterpart.
- Opcode is inst[6:0], funct3 is inst[14:12], funct7[5] is inst[30].
- Immediate decode:
  - I-type (opcodes 0000011, 0010011, 1100111, 1110011): sext(inst[31:20]).
  - S-type (0100011): sext({inst[31:25], inst[11:7]}).
  - B-type (1100011): sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}.
  - J-type (1101111): sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - R-type and any other opcode: 0.
- ALU operation, when opcode is R-type (0110011) or OP-IMM (0010011), selected by funct3:
  - 000: ADD; SUB only when R-type and funct7[5]=1. OP-IMM always adds.
  - 001: SLL by in_b[4:0].
  - 010: SLT signed, result 1 or 0.
  - 011: SLTU, result 1 or 0.
  - 100: XOR.
  - 101: SRL, or SRA when funct7[5]=1 (both R-type and OP-IMM). Shift amount is in_b[4:0].
  - 110: OR.
  - 111: AND.
- All other opcodes (JAL, JALR, AUIPC, LUI, load, store, branch, system): result = in_a + in_b, modulo 2^32. Thus JAL/JALR with in_b=4 gives the link address, and AUIPC gives PC+imm.
- take_b is asserted only when opcode is B-type. By funct3:
  - 000 BEQ: in_a==in_b.
  - 001 BNE: in_a!=in_b.
  - 100 BLT: signed <.
  - 101 BGE: signed >=.
  - 110 BLTU: unsigned <.
  - 111 BGEU: unsigned >=.
  - 010/011: 0.
- For any non-branch opcode, take_b = 0.
- Edge cases:
  - Arithmetic wraps silently.
  - Shift amounts use only 5 bits; in_b[31:5] are ignored.
  - SRA of a negative value fills with 1s.
  - Signed compares treat bit 31 as the sign.
- X-free: every opcode and funct3 combination yields a defined value.

Decomposition:
- Shared package holds:
  - opcode constants: OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_SYSTEM;
  - funct3 constants for ALU and branch;
  - imm-format enum (I, S, B, U, J, NONE).
- One sub-module is natural: rv32_imm_decode (combinational inst→imm). The ALU, compare logic and output registers live in the top.

Test Plan:
- R-type SUB (funct7=0100000, f3=000), in_a=5, in_b=7 -> result=0xFFFFFFFE. ADD form gives 12.
- OP-IMM SRAI inst=0x4030D093, in_a=0x80000000, in_b=imm -> imm=0x403 (shamt 3); result=0xF0000000. SRLI (inst[30]=0) gives 0x10000000.
- BLT vs BLTU with in_a=0xFFFFFFFF, in_b=1 -> BLT take_b=1; BLTU take_b=0. BEQ with equal operands gives 1. ADD-type opcode gives take_b=0.
- Immediate decode:
  - JAL inst=0xFFDFF0EF -> imm=0xFFFFFFFC.
  - LUI inst=0x123450B7 -> imm=0x12345000.
  - SW inst=0xFE112E23 -> imm=0xFFFFFFFC.
  - BEQ with offset -8 -> imm=0xFFFFFFF8.
  - R-type -> imm=0.
- JAL/AUIPC path: opcode 1101111, in_a=0x100, in_b=4 -> result=0x104. SLTIU with in_a=0, in_b=0xFFFFFFFF -> result=1.
- Registers: hold resetn=0 for one clock -> result_q/take_b_q/imm_q=0. Release reset, apply ADD 3+4 -> result_q=7 one clock later. Assert resetn=0 mid-stream -> *_q clear at the next edge.
